rtc_wb2reg: RTL and testbench

RTC_WB2REG -- requirements
Module: rtc_wb2reg

---
 rtl/rtc_pkg.sv | 15 +
 rtl/rtc_wb2reg_tmr.sv | 31 +++
 rtl/rtc_wb2reg.sv | 113 +++++++++++
 tb/tb_rtc_wb2reg.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC Wishbone-to-register-bus bridge.
// Holds the bridge FSM encoding and the default error read-data pattern.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } wb_state_e;

  localparam logic [31:0] RTC_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [7:0]  TO_CNT_MAX   = 8'hFF;

endpackage

// File: rtl/rtc_wb2reg_tmr.sv
// Register-bus wait counter: cleared while the bridge is idle, counts REQ cycles
// without reg_ack, and flags the last cycle before the timeout limit.
module rtc_wb2reg_tmr #(
  parameter int TIMEOUT = 255
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // Terminal one cycle early so the REQ phase lasts exactly TIMEOUT cycles.
  assign o_term = (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/rtc_wb2reg.sv
// Wishbone slave to RTC register-bus bridge with reg_ack timeout, error response
// and drain of transactions the master abandons while the register bus is busy.
module rtc_wb2reg
  import rtc_pkg::*;
#(
  parameter int          AW       = 5,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = RTC_ERR_DATA
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [AW+1:0] wbs_adr_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          reg_cs,
  output logic [AW-1:0] reg_addr,
  output logic [31:0]   reg_wdata,
  output logic [3:0]    reg_be,
  output logic          reg_wr,
  input  logic [31:0]   reg_rdata,
  input  logic          reg_ack,
  output logic [7:0]    timeout_cnt
);

  wb_state_e r_state;
  logic      r_abort;
  logic      w_term;
  logic      w_drain;
  logic      w_unused;

  // Byte-lane bits of the address carry no information on a word bus.
  assign w_unused = ^wbs_adr_i[1:0];
  assign w_drain  = r_abort || !wbs_cyc_i;

  rtc_wb2reg_tmr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .sys_clk (sys_clk),
    .reset   (reset),
    .i_clr   (r_state == ST_IDLE),
    .i_en    ((r_state == ST_REQ) && !reg_ack),
    .o_term  (w_term)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_abort     <= 1'b0;
      reg_cs      <= 1'b0;
      reg_wr      <= 1'b0;
      reg_addr    <= '0;
      reg_be      <= '0;
      reg_wdata   <= '0;
      wbs_ack_o   <= 1'b0;
      wbs_err_o   <= 1'b0;
      wbs_dat_o   <= '0;
      timeout_cnt <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            reg_addr  <= wbs_adr_i[AW+1:2];
            reg_wr    <= wbs_we_i;
            reg_be    <= wbs_sel_i;
            reg_wdata <= wbs_dat_i;
            reg_cs    <= 1'b1;
            r_abort   <= 1'b0;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The register bus cannot be aborted: a dropped cycle only suppresses the response.
          if (reg_ack) begin
            reg_cs <= 1'b0;
            if (w_drain) begin
              r_state <= ST_DRAIN;
            end else begin
              wbs_dat_o <= reg_wr ? 32'h0 : reg_rdata;
              wbs_ack_o <= 1'b1;
              r_state   <= ST_RESP;
            end
          end else if (w_term) begin
            reg_cs <= 1'b0;
            if (timeout_cnt != TO_CNT_MAX) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            if (w_drain) begin
              r_state <= ST_DRAIN;
            end else begin
              wbs_dat_o <= ERR_DATA;
              wbs_err_o <= 1'b1;
              r_state   <= ST_RESP;
            end
          end else if (!wbs_cyc_i) begin
            r_abort <= 1'b1;
          end
        end
        ST_RESP:  r_state <= ST_IDLE;
        ST_DRAIN: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_wb2reg.sv
// Directed self-checking bench for rtc_wb2reg (AW=5, TIMEOUT=8).
module tb_rtc_wb2reg;

  logic        sys_clk;
  logic        reset;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [6:0]  wbs_adr_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic        reg_cs, reg_wr, reg_ack;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [3:0]  reg_be;
  logic [7:0]  timeout_cnt;

  int total = 0;
  int bad   = 0;

  rtc_wb2reg #(.AW(5), .TIMEOUT(8)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_err_o   (wbs_err_o),
    .reg_cs      (reg_cs),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_be      (reg_be),
    .reg_wr      (reg_wr),
    .reg_rdata   (reg_rdata),
    .reg_ack     (reg_ack),
    .timeout_cnt (timeout_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Runs one Wishbone transaction; reg_ack is raised in REQ cycle ack_delay (-1 = never).
  // lat counts clock edges from strobe until ack/err is seen.
  task automatic do_txn(input logic [6:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input int ack_delay, input logic [31:0] rdata,
                        output logic o_ack, output logic o_err, output logic [31:0] o_dat,
                        output int lat, output int cs_cyc);
    wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
    reg_rdata = rdata; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    o_ack = 1'b0; o_err = 1'b0; o_dat = '0; lat = -1; cs_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      reg_ack = 1'b0;
      if (reg_cs) cs_cyc++;
      if (wbs_ack_o || wbs_err_o) begin
        o_ack = wbs_ack_o; o_err = wbs_err_o; o_dat = wbs_dat_o; lat = i;
        break;
      end
      reg_ack = (ack_delay == i - 1);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; reg_ack = 1'b0;
    total++;
    if (lat < 0) begin bad++; $display("FAIL txn_bound: no ack/err within 40 cycles, adr=%h", adr); end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = '0;
    wbs_sel_i = '0; wbs_dat_i = '0; reg_rdata = '0; reg_ack = 0;
    tick(); tick();
    total++;
    if ({reg_cs, reg_wr, wbs_ack_o, wbs_err_o} !== 4'b0000) begin
      bad++; $display("FAIL rst_ctrl: got %b want 0000", {reg_cs, reg_wr, wbs_ack_o, wbs_err_o});
    end
    total++;
    if ({reg_addr, reg_be, reg_wdata, wbs_dat_o, timeout_cnt} !== '0) begin
      bad++; $display("FAIL rst_data: addr=%h be=%h wdata=%h dat=%h tcnt=%0d want all 0",
                      reg_addr, reg_be, reg_wdata, wbs_dat_o, timeout_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic a, e; logic [31:0] d; int lat, cs;
    do_txn(7'h04, 1'b1, 4'b0001, 32'h0000_0030, 2, 32'hFFFF_FFFF, a, e, d, lat, cs);
    total++; if ({a, e} !== 2'b10) begin bad++; $display("FAIL wr_resp: ack/err=%b want 10", {a, e}); end
    total++; if (lat !== 4) begin bad++; $display("FAIL wr_latency: got %0d want 4", lat); end
    total++; if (cs !== 3) begin bad++; $display("FAIL wr_cs_cycles: got %0d want 3", cs); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wr_dat_o: got %h want 0", d); end
    total++;
    if ({reg_addr, reg_be, reg_wr, reg_wdata} !== {5'd1, 4'b0001, 1'b1, 32'h30}) begin
      bad++; $display("FAIL wr_regbus: addr=%h be=%b wr=%b wdata=%h want 01 0001 1 00000030",
                      reg_addr, reg_be, reg_wr, reg_wdata);
    end
    total++;
    if ({reg_cs, wbs_ack_o, wbs_err_o} !== 3'b000) begin
      bad++; $display("FAIL wr_single_pulse: cs/ack/err=%b want 000", {reg_cs, wbs_ack_o, wbs_err_o});
    end
  endtask

  task automatic test_read();
    logic a, e; logic [31:0] d; int lat, cs;
    do_txn(7'h48, 1'b0, 4'b1111, 32'h0, 0, 32'h0000_0005, a, e, d, lat, cs);
    total++; if ({a, e} !== 2'b10) begin bad++; $display("FAIL rd_resp: ack/err=%b want 10", {a, e}); end
    total++; if (d !== 32'h5) begin bad++; $display("FAIL rd_dat_o: got %h want 00000005", d); end
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_min_latency: got %0d want 2", lat); end
    total++; if ({reg_addr, reg_wr} !== {5'h12, 1'b0}) begin
      bad++; $display("FAIL rd_regbus: addr=%h wr=%b want 12 0", reg_addr, reg_wr);
    end
  endtask

  task automatic test_timeout();
    logic a, e; logic [31:0] d; int lat, cs;
    do_txn(7'h00, 1'b0, 4'b1111, 32'h0, -1, 32'h1111_1111, a, e, d, lat, cs);
    total++; if ({a, e} !== 2'b01) begin bad++; $display("FAIL to_resp: ack/err=%b want 01", {a, e}); end
    total++; if (cs !== 8) begin bad++; $display("FAIL to_cs_cycles: got %0d want 8", cs); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_dat_o: got %h want deadbeef", d); end
    total++; if (timeout_cnt !== 8'd1) begin bad++; $display("FAIL to_count: got %0d want 1", timeout_cnt); end
    total++; if (wbs_err_o !== 1'b0) begin bad++; $display("FAIL to_single_pulse: err=%b want 0", wbs_err_o); end
  endtask

  task automatic test_ack_vs_timeout();
    logic a, e; logic [31:0] d; int lat, cs;
    do_txn(7'h0C, 1'b0, 4'b1111, 32'h0, 7, 32'h0000_00A5, a, e, d, lat, cs);
    total++; if ({a, e} !== 2'b10) begin bad++; $display("FAIL collide_resp: ack/err=%b want 10", {a, e}); end
    total++; if (d !== 32'hA5) begin bad++; $display("FAIL collide_dat: got %h want 000000a5", d); end
    total++; if (timeout_cnt !== 8'd1) begin bad++; $display("FAIL collide_count: got %0d want 1", timeout_cnt); end
  endtask

  task automatic test_ignored_ack();
    reg_ack = 1'b1;
    tick(); tick();
    reg_ack = 1'b0;
    total++;
    if ({reg_cs, wbs_ack_o, wbs_err_o, timeout_cnt} !== {3'b000, 8'd1}) begin
      bad++; $display("FAIL idle_ack: cs/ack/err=%b tcnt=%0d want 000 1",
                      {reg_cs, wbs_ack_o, wbs_err_o}, timeout_cnt);
    end
  endtask

  task automatic test_abort();
    logic a, e; logic [31:0] d; int lat, cs;
    wbs_adr_i = 7'h08; wbs_we_i = 0; wbs_sel_i = 4'hF; reg_rdata = 32'h77;
    wbs_cyc_i = 1; wbs_stb_i = 1;
    tick();
    wbs_cyc_i = 0; wbs_stb_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({reg_cs, wbs_ack_o, wbs_err_o} !== 3'b100) begin
        bad++; $display("FAIL abort_hold_%0d: cs/ack/err=%b want 100", i, {reg_cs, wbs_ack_o, wbs_err_o});
      end
    end
    reg_ack = 1;
    tick();
    reg_ack = 0;
    total++;
    if ({reg_cs, wbs_ack_o, wbs_err_o} !== 3'b000) begin
      bad++; $display("FAIL abort_drain: cs/ack/err=%b want 000", {reg_cs, wbs_ack_o, wbs_err_o});
    end
    tick();
    total++;
    if ({reg_cs, wbs_ack_o, wbs_err_o} !== 3'b000) begin
      bad++; $display("FAIL abort_idle: cs/ack/err=%b want 000", {reg_cs, wbs_ack_o, wbs_err_o});
    end
    do_txn(7'h08, 1'b0, 4'hF, 32'h0, 0, 32'h77, a, e, d, lat, cs);
    total++;
    if ({a, e, d, lat} !== {2'b10, 32'h77, 32'sd2}) begin
      bad++; $display("FAIL abort_next: ack/err=%b dat=%h lat=%0d want 10 00000077 2", {a, e}, d, lat);
    end
  endtask

  task automatic test_back_to_back();
    wbs_adr_i = 7'h0C; wbs_we_i = 0; wbs_sel_i = 4'hF; reg_rdata = 32'h11;
    wbs_cyc_i = 1; wbs_stb_i = 1;
    tick(); reg_ack = 1; tick(); reg_ack = 0;
    total++;
    if ({wbs_ack_o, wbs_dat_o} !== {1'b1, 32'h11}) begin
      bad++; $display("FAIL b2b_first: ack=%b dat=%h want 1 00000011", wbs_ack_o, wbs_dat_o);
    end
    wbs_adr_i = 7'h10; reg_rdata = 32'h22;
    tick();
    total++;
    if ({reg_cs, wbs_ack_o} !== 2'b00) begin
      bad++; $display("FAIL b2b_idle_gap: cs/ack=%b want 00", {reg_cs, wbs_ack_o});
    end
    tick();
    total++;
    if ({reg_cs, reg_addr} !== {1'b1, 5'd4}) begin
      bad++; $display("FAIL b2b_second_req: cs=%b addr=%h want 1 04", reg_cs, reg_addr);
    end
    reg_ack = 1; tick(); reg_ack = 0;
    total++;
    if ({wbs_ack_o, wbs_dat_o} !== {1'b1, 32'h22}) begin
      bad++; $display("FAIL b2b_second: ack=%b dat=%h want 1 00000022", wbs_ack_o, wbs_dat_o);
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    tick();
  endtask

  task automatic test_reset_mid_req();
    logic a, e; logic [31:0] d; int lat, cs;
    wbs_adr_i = 7'h14; wbs_we_i = 1; wbs_sel_i = 4'b0011; wbs_dat_i = 32'hCAFE;
    wbs_cyc_i = 1; wbs_stb_i = 1;
    tick(); tick();
    total++; if (reg_cs !== 1'b1) begin bad++; $display("FAIL rmid_pre: cs=%b want 1", reg_cs); end
    reset = 1'b1;
    #1;
    total++;
    if ({reg_cs, reg_wr, reg_addr, reg_be, reg_wdata, wbs_dat_o, wbs_ack_o, wbs_err_o, timeout_cnt} !== '0) begin
      bad++; $display("FAIL rmid_async: cs=%b wr=%b addr=%h be=%h wdata=%h tcnt=%0d want all 0",
                      reg_cs, reg_wr, reg_addr, reg_be, reg_wdata, timeout_cnt);
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    #2 reset = 1'b0;
    tick();
    do_txn(7'h18, 1'b0, 4'hF, 32'h0, 1, 32'h1234, a, e, d, lat, cs);
    total++;
    if ({a, e, d, lat} !== {2'b10, 32'h1234, 32'sd3}) begin
      bad++; $display("FAIL rmid_next: ack/err=%b dat=%h lat=%0d want 10 00001234 3", {a, e}, d, lat);
    end
  endtask

  task automatic test_saturate();
    logic a, e; logic [31:0] d; int lat, cs;
    for (int i = 0; i < 300; i++) begin
      do_txn(7'h00, 1'b0, 4'hF, 32'h0, -1, 32'h0, a, e, d, lat, cs);
      if (i == 253) begin
        total++;
        if (timeout_cnt !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", timeout_cnt); end
      end
    end
    total++;
    if (timeout_cnt !== 8'd255) begin bad++; $display("FAIL sat_final: got %0d want 255", timeout_cnt); end
    total++;
    if ({a, e} !== 2'b01) begin bad++; $display("FAIL sat_last_err: ack/err=%b want 01", {a, e}); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_vs_timeout();
    test_ignored_ack();
    test_abort();
    test_back_to_back();
    test_reset_mid_req();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
